lsl_seq: RTL and testbench

- Iterative logical-shift-left unit for the ALU; the left-shift counterpart to the existing logical-shift-right operation.
- Shifts a 32-bit operand left by a 4-bit amount (0–15), one bit position per clock cycle.
- Uses a start/busy/done handshake and produces the same 4-bit NZCV flag vector as the other ALU operations.
- The ALU result mux selects Result/Flag when done pulses.

---
 rtl/lsl_seq.sv | 89 ++++++++
 tb/tb_lsl_seq.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/lsl_seq.sv
// Iterative logical-shift-left unit: shifts a WIDTH-bit operand left by 0..2^SHW-1 bits,
// one bit per clock, with a start/busy/done handshake and an NZCV flag result.
module lsl_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [SHW-1:0]   in2,
    input  logic             S,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       Flag,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] working;
    logic [SHW-1:0]   count;
    logic             s_latch;
    logic [WIDTH-1:0] shifted;

    assign shifted = {working[WIDTH-2:0], 1'b0};

    // Outputs are registered on the edge that enters DONE, so Result/Flag/done
    // are all valid together in the single DONE cycle. The carry is taken
    // straight from the bit leaving the working register on that final edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            working <= '0;
            count   <= '0;
            s_latch <= 1'b0;
            Result  <= '0;
            Flag    <= 4'b0000;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        working <= in1;
                        count   <= in2;
                        s_latch <= S;
                        busy    <= 1'b1;
                        if (in2 == '0) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            Result <= in1;
                            if (S)
                                Flag <= {in1[WIDTH-1], (in1 == '0), 1'b0, 1'b0};
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    working <= shifted;
                    count   <= count - 1'b1;
                    if (count == SHW'(1)) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        Result <= shifted;
                        if (s_latch)
                            Flag <= {shifted[WIDTH-1], (shifted == '0), working[WIDTH-1], 1'b0};
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsl_seq.sv
// Directed bench for lsl_seq: expected Result/Flag/latency come from a small shift model
// and are queued when each request is driven, then popped when done pulses.
module tb_lsl_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] in1;
    logic [3:0]  in2;
    logic        S;
    logic [31:0] Result;
    logic [3:0]  Flag;
    logic        busy;
    logic        done;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
    } exp_t;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    logic [3:0] model_flag = 4'b0000;

    lsl_seq #(.WIDTH(32), .SHW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2), .S(S),
        .Result(Result), .Flag(Flag), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [3:0] b, input logic s);
        exp_t        e;
        logic [31:0] r;
        logic        c;
        r = a << b;
        c = (b == 4'd0) ? 1'b0 : a[32 - int'(b)];
        if (s)
            model_flag = {r[31], (r == 32'd0), c, 1'b0};
        e.res = r;
        e.flg = model_flag;
        e.lat = int'(b) + 1;
        sb.push_back(e);
    endtask

    // Drive one request; optionally re-pulse start (with different operands) at poke_cyc.
    task automatic run_op(input logic [31:0] a, input logic [3:0] b, input logic s, input int poke_cyc);
        exp_t e;
        logic got;
        int   extra;
        push_exp(a, b, s);
        in1 = a; in2 = b; S = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in1 = $urandom; in2 = 4'($urandom); S = 1'($urandom);
        got = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            start = (k == poke_cyc);
            if (k == poke_cyc) begin
                in1 = 32'd1; in2 = 4'd3;
            end
            if (done === 1'b1) begin
                got = 1'b1;
                e = sb.pop_front();
                check("latency", k, e.lat);
                check("result", Result, e.res);
                check("flag", {28'd0, Flag}, {28'd0, e.flg});
                check("busy_at_done", {31'd0, busy}, 32'd1);
                $display("[TB] op in1=%h in2=%0d S=%0b -> Result=%h Flag=%b after %0d cycles",
                         a, b, s, Result, Flag, k);
            end else begin
                check("busy_in_flight", {31'd0, busy}, 32'd1);
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        check("done_seen", {31'd0, got}, 32'd1);
        if (!got && sb.size() > 0)
            void'(sb.pop_front());
        extra = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (k == 0)
                check("busy_after_done", {31'd0, busy}, 32'd0);
            if (done === 1'b1)
                extra++;
        end
        check("single_done", extra, 0);
    endtask

    initial begin
        int          stray;
        logic [31:0] hold_res;
        rst = 1'b1; start = 1'b0; in1 = 32'd0; in2 = 4'd0; S = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", Result, 32'd0);
        check("rst_flag", {28'd0, Flag}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(32'd2, 4'd3, 1'b1, 0);
        run_op(32'd5, 4'd0, 1'b1, 0);
        run_op(32'd0, 4'd0, 1'b1, 0);
        run_op(32'h0001_0000, 4'd15, 1'b1, 0);
        run_op(32'hC000_0000, 4'd2, 1'b0, 0);
        run_op(32'd6, 4'd9, 1'b1, 3);
        run_op(32'h8000_0001, 4'd1, 1'b1, 0);

        // Result holds between operations
        hold_res = Result;
        repeat (3) @(posedge clk);
        #1;
        check("result_hold", Result, hold_res);

        // Abort an operation with asynchronous reset in cycle 5
        in1 = 32'd10; in2 = 4'd10; S = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_result", Result, 32'd0);
        check("abort_flag", {28'd0, Flag}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_flag = 4'b0000;
        stray = 0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1)
                stray++;
        end
        check("no_done_after_abort", stray, 0);
        $display("[TB] reset abort checked, Result=%h Flag=%b", Result, Flag);

        run_op(32'd10, 4'd6, 1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
